// File: rtl/cell_bist_ctrl_if.sv
// ---------------------------------------------------------------------------
// cell_bist_ctrl_if
// Bundles the BIST sequencer's control, CUT stimulus/observation and result
// signals so the controller and its environment connect through one port.
//
//   START, ABORT      sweep request / stop request (single-cycle pulses)
//   LAST_VEC          final stimulus vector of the sweep
//   MASK              per-output compare enable, static during a sweep
//   OBS, EXP          observed CUT outputs and golden expectation
//   VEC               stimulus driven to every CUT input
//   BUSY, DONE        sweep running / sweep completed normally
//   FAIL_MASK         sticky per-output mismatch mask
//   FIRST_VALID/VEC   first-failing-vector record
//   SIGNATURE         MISR compaction of the masked observations
//
// master = environment / test driver, slave = the BIST controller.
// ---------------------------------------------------------------------------
interface cell_bist_ctrl_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 8
);
  logic             START;
  logic             ABORT;
  logic [N_IN-1:0]  LAST_VEC;
  logic [N_OUT-1:0] MASK;
  logic [N_OUT-1:0] OBS;
  logic [N_OUT-1:0] EXP;
  logic [N_IN-1:0]  VEC;
  logic             BUSY;
  logic             DONE;
  logic [N_OUT-1:0] FAIL_MASK;
  logic             FIRST_VALID;
  logic [N_IN-1:0]  FIRST_VEC;
  logic [N_OUT-1:0] SIGNATURE;

  modport master (
    output START, ABORT, LAST_VEC, MASK, OBS, EXP,
    input  VEC, BUSY, DONE, FAIL_MASK, FIRST_VALID, FIRST_VEC, SIGNATURE
  );

  modport slave (
    input  START, ABORT, LAST_VEC, MASK, OBS, EXP,
    output VEC, BUSY, DONE, FAIL_MASK, FIRST_VALID, FIRST_VEC, SIGNATURE
  );
endinterface

// File: rtl/cell_bist_ctrl.sv
// ---------------------------------------------------------------------------
// cell_bist_ctrl
// Built-in self-test sequencer for the standard-cell characterisation array.
// Steps a stimulus vector from 0 up to a latched last vector, waits SETTLE
// cycles per vector for the cells to settle, then compares the masked CUT
// outputs against the golden values, accumulates a sticky fail mask,
// records the first failing vector and folds the observations into a MISR.
//
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    cell_bist_ctrl_if.slave (control, CUT I/O and results)
// ---------------------------------------------------------------------------
module cell_bist_ctrl #(
  parameter int               N_IN   = 4,
  parameter int               N_OUT  = 8,
  parameter int               SETTLE = 2,
  parameter logic [N_OUT-1:0] POLY   = 8'h1D
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  cell_bist_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPT,
    ST_DONE
  } state_t;

  // The settle counter is loaded with SETTLE-1 so that reaching zero marks
  // the last of exactly SETTLE wait cycles.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic [N_IN-1:0]  lastVec;
  logic [N_IN-1:0]  vecQ;
  logic             busyQ;
  logic             doneQ;
  logic [N_OUT-1:0] failQ;
  logic             firstValidQ;
  logic [N_IN-1:0]  firstVecQ;
  logic [N_OUT-1:0] sigQ;

  logic [N_OUT-1:0] err;
  logic [N_OUT-1:0] sigNext;

  // Masked mismatch for the current vector and the next MISR state: shift
  // left, fold the outgoing MSB back through the polynomial taps, then mix
  // in the masked observation.
  always_comb begin
    err     = (bus.OBS ^ bus.EXP) & bus.MASK;
    sigNext = {sigQ[N_OUT-2:0], 1'b0}
            ^ (sigQ[N_OUT-1] ? POLY : '0)
            ^ (bus.OBS & bus.MASK);
  end

  // Sequencer. ABORT is only looked at while running and overrides the
  // WAIT/CAPT update, leaving partial results visible. In IDLE/DONE a START
  // always wins over a simultaneous ABORT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lastVec     <= '0;
      vecQ        <= '0;
      busyQ       <= 1'b0;
      doneQ       <= 1'b0;
      failQ       <= '0;
      firstValidQ <= 1'b0;
      firstVecQ   <= '0;
      sigQ        <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.START) begin
            vecQ        <= '0;
            failQ       <= '0;
            firstValidQ <= 1'b0;
            firstVecQ   <= '0;
            sigQ        <= '0;
            lastVec     <= bus.LAST_VEC;
            cnt         <= CNT_LOAD;
            busyQ       <= 1'b1;
            doneQ       <= 1'b0;
            state       <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (bus.ABORT) begin
            busyQ <= 1'b0;
            doneQ <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            state <= ST_CAPT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ST_CAPT: begin
          if (bus.ABORT) begin
            busyQ <= 1'b0;
            doneQ <= 1'b0;
            state <= ST_IDLE;
          end else begin
            failQ <= failQ | err;
            sigQ  <= sigNext;
            if ((err != '0) && !firstValidQ) begin
              firstValidQ <= 1'b1;
              firstVecQ   <= vecQ;
            end
            // The sweep stops on the last vector instead of wrapping, so an
            // all-ones LAST_VEC still covers the full input space.
            if (vecQ == lastVec) begin
              busyQ <= 1'b0;
              doneQ <= 1'b1;
              state <= ST_DONE;
            end else begin
              vecQ  <= vecQ + N_IN'(1);
              cnt   <= CNT_LOAD;
              state <= ST_WAIT;
            end
          end
        end

        default: begin
          busyQ <= 1'b0;
          doneQ <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.VEC         = vecQ;
  assign bus.BUSY        = busyQ;
  assign bus.DONE        = doneQ;
  assign bus.FAIL_MASK   = failQ;
  assign bus.FIRST_VALID = firstValidQ;
  assign bus.FIRST_VEC   = firstVecQ;
  assign bus.SIGNATURE   = sigQ;

endmodule
